// File: rtl/instruction_decode_stage.sv
// RV32I(+M) instruction decode stage with a 2-entry skid buffer.
// Ports: clk/rst, flush, in_* valid/ready word input, out_* decoded record, invalid_count.
module instruction_decode_stage #(
  parameter int ADDR_WIDTH  = 32,
  parameter int ENABLE_M    = 0,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instruction,
  input  logic [ADDR_WIDTH-1:0]  in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [2:0]             out_funct3,
  output logic [6:0]             out_funct7,
  output logic [31:0]            out_immediate,
  output logic [3:0]             out_class,
  output logic                   out_invalid,
  output logic [COUNT_WIDTH-1:0] invalid_count
);

  localparam logic [3:0] CL_NONE   = 4'd0;
  localparam logic [3:0] CL_LUI    = 4'd1;
  localparam logic [3:0] CL_AUIPC  = 4'd2;
  localparam logic [3:0] CL_JAL    = 4'd3;
  localparam logic [3:0] CL_JALR   = 4'd4;
  localparam logic [3:0] CL_BRANCH = 4'd5;
  localparam logic [3:0] CL_LOAD   = 4'd6;
  localparam logic [3:0] CL_STORE  = 4'd7;
  localparam logic [3:0] CL_ALUIMM = 4'd8;
  localparam logic [3:0] CL_ALU    = 4'd9;
  localparam logic [3:0] CL_FENCE  = 4'd10;
  localparam logic [3:0] CL_CSR    = 4'd11;
  localparam logic [3:0] CL_ECALL  = 4'd12;
  localparam logic [3:0] CL_EBREAK = 4'd13;
  localparam logic [3:0] CL_MRET   = 4'd14;
  localparam logic [3:0] CL_MULDIV = 4'd15;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [31:0]           imm;
    logic [3:0]            cls;
    logic                  invalid;
  } rec_t;

  rec_t dec;
  rec_t outReg;
  rec_t skidReg;
  logic outValid;
  logic skidValid;
  logic accept;
  logic [COUNT_WIDTH-1:0] invCount;

  logic [31:0] ins;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [24:0] sysField;
  logic [3:0]  cls;
  logic [31:0] imm;
  logic        isI;

  assign ins      = in_instruction;
  assign op       = ins[6:0];
  assign f3       = ins[14:12];
  assign f7       = ins[31:25];
  assign sysField = ins[31:7];

  always_comb begin
    cls = CL_NONE;
    if (ins[1:0] == 2'b11) begin
      case (op)
        7'b0110111: cls = CL_LUI;
        7'b0010111: cls = CL_AUIPC;
        7'b1101111: cls = CL_JAL;
        7'b1100111: if (f3 == 3'b000) cls = CL_JALR;
        7'b1100011: begin
          if (f3 != 3'b010 && f3 != 3'b011) cls = CL_BRANCH;
        end
        7'b0000011: begin
          if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111)
            cls = CL_LOAD;
        end
        7'b0100011: if (f3 <= 3'b010) cls = CL_STORE;
        7'b0010011: begin
          // shifts carry funct7 in the immediate field
          if (f3 == 3'b001) begin
            if (f7 == 7'b0000000) cls = CL_ALUIMM;
          end else if (f3 == 3'b101) begin
            if (f7 == 7'b0000000 || f7 == 7'b0100000)
              cls = CL_ALUIMM;
          end else begin
            cls = CL_ALUIMM;
          end
        end
        7'b0110011: begin
          if (f7 == 7'b0000000)
            cls = CL_ALU;
          else if (f7 == 7'b0100000 &&
                   (f3 == 3'b000 || f3 == 3'b101))
            cls = CL_ALU;
          else if (f7 == 7'b0000001 && ENABLE_M != 0)
            cls = CL_MULDIV;
        end
        7'b0001111: if (f3 == 3'b000) cls = CL_FENCE;
        7'b1110011: begin
          if (f3 != 3'b000 && f3 != 3'b100)
            cls = CL_CSR;
          else if (f3 == 3'b000) begin
            if (sysField == 25'h0000000) cls = CL_ECALL;
            else if (sysField == 25'h0002000) cls = CL_EBREAK;
            else if (sysField == 25'h0604000) cls = CL_MRET;
          end
        end
        default: cls = CL_NONE;
      endcase
    end
  end

  assign isI = (cls == CL_JALR) || (cls == CL_LOAD) ||
               (cls == CL_ALUIMM);

  always_comb begin
    imm = '0;
    unique case (1'b1)
      isI:
        imm = {{20{ins[31]}}, ins[31:20]};
      cls == CL_STORE:
        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      cls == CL_BRANCH:
        imm = {{19{ins[31]}}, ins[31], ins[7],
               ins[30:25], ins[11:8], 1'b0};
      cls == CL_LUI, cls == CL_AUIPC:
        imm = {ins[31:12], 12'b0};
      cls == CL_JAL:
        imm = {{11{ins[31]}}, ins[31], ins[19:12],
               ins[20], ins[30:21], 1'b0};
      cls == CL_CSR:
        imm = {27'b0, ins[19:15]};
      default:
        imm = '0;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.rd      = ins[11:7];
    dec.rs1     = ins[19:15];
    dec.rs2     = ins[24:20];
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.imm     = imm;
    dec.cls     = cls;
    dec.invalid = (cls == CL_NONE);
  end

  assign in_ready = !skidValid;
  assign accept   = in_valid && !skidValid && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid  <= 1'b0;
      skidValid <= 1'b0;
      outReg    <= '0;
      skidReg   <= '0;
    end else if (flush) begin
      outValid  <= 1'b0;
      skidValid <= 1'b0;
    end else if (!outValid || out_ready) begin
      if (skidValid) begin
        outReg    <= skidReg;
        outValid  <= 1'b1;
        skidValid <= 1'b0;
        skidReg   <= '0;
      end else if (accept) begin
        outReg   <= dec;
        outValid <= 1'b1;
      end else begin
        outValid <= 1'b0;
      end
    end else if (accept) begin
      skidReg   <= dec;
      skidValid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      invCount <= '0;
    end else if (outValid && out_ready && outReg.invalid &&
                 invCount != {COUNT_WIDTH{1'b1}}) begin
      invCount <= invCount + COUNT_WIDTH'(1);
    end
  end

  assign out_valid     = outValid;
  assign out_pc        = outReg.pc;
  assign out_rd        = outReg.rd;
  assign out_rs1       = outReg.rs1;
  assign out_rs2       = outReg.rs2;
  assign out_funct3    = outReg.funct3;
  assign out_funct7    = outReg.funct7;
  assign out_immediate = outReg.imm;
  assign out_class     = outReg.cls;
  assign out_invalid   = outReg.invalid;
  assign invalid_count = invCount;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed self-checking bench for instruction_decode_stage.
// Second instance built with ENABLE_M=1 for the MULDIV case.
module tb_instruction_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instruction = '0;
  logic [31:0] in_pc = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_invalid;
  logic [31:0] out_pc, out_immediate;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [3:0]  out_class;
  logic [7:0]  invalid_count;

  logic        m_in_ready, m_out_valid, m_out_invalid;
  logic [31:0] m_out_pc, m_out_immediate;
  logic [4:0]  m_out_rd, m_out_rs1, m_out_rs2;
  logic [2:0]  m_out_funct3;
  logic [6:0]  m_out_funct7;
  logic [3:0]  m_out_class;
  logic [7:0]  m_invalid_count;

  int checks = 0;
  int errors = 0;
  int expInv = 0;

  always #5 clk = ~clk;

  instruction_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_immediate(out_immediate), .out_class(out_class),
    .out_invalid(out_invalid), .invalid_count(invalid_count)
  );

  instruction_decode_stage #(.ENABLE_M(1)) dutM (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(m_in_ready),
    .in_instruction(in_instruction), .in_pc(in_pc),
    .out_valid(m_out_valid), .out_ready(out_ready),
    .out_pc(m_out_pc), .out_rd(m_out_rd),
    .out_rs1(m_out_rs1), .out_rs2(m_out_rs2),
    .out_funct3(m_out_funct3), .out_funct7(m_out_funct7),
    .out_immediate(m_out_immediate), .out_class(m_out_class),
    .out_invalid(m_out_invalid), .invalid_count(m_invalid_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %0b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %0b want 1", in_ready);
    end
    checks++;
    if (invalid_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_count got %0h want 0", invalid_count);
    end
    checks++;
    if ({out_class, out_invalid, out_immediate, out_pc} !== '0) begin
      errors++;
      $display("FAIL reset_fields got %0d/%0b/%0h/%0h want 0",
               out_class, out_invalid, out_immediate, out_pc);
    end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instruction = 32'h00500093;
    in_pc = 32'h100;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL addi_valid got %0b want 1", out_valid);
    end
    checks++;
    if (out_class !== 4'd8 || out_invalid !== 1'b0) begin
      errors++;
      $display("FAIL addi_class got %0d/%0b want 8/0",
               out_class, out_invalid);
    end
    checks++;
    if (out_rd !== 5'd1 || out_rs1 !== 5'd0 ||
        out_immediate !== 32'd5 || out_pc !== 32'h100) begin
      errors++;
      $display("FAIL addi_fields got rd%0d rs1 %0d imm%0h pc%0h want 1 0 5 100",
               out_rd, out_rs1, out_immediate, out_pc);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL addi_drain got %0b want 0", out_valid);
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  cls;
    logic [31:0] imm;
  } vec_t;

  task automatic test_formats();
    vec_t v [20] = '{
      '{32'h123450b7, 4'd1,  32'h12345000},
      '{32'h00001117, 4'd2,  32'h00001000},
      '{32'hffdff0ef, 4'd3,  32'hfffffffc},
      '{32'h00008067, 4'd4,  32'h00000000},
      '{32'h00208463, 4'd5,  32'h00000008},
      '{32'h0020a463, 4'd0,  32'h00000000},
      '{32'hffc12283, 4'd6,  32'hfffffffc},
      '{32'h00512623, 4'd7,  32'h0000000c},
      '{32'h4030d093, 4'd8,  32'h00000403},
      '{32'h40309093, 4'd0,  32'h00000000},
      '{32'h402081b3, 4'd9,  32'h00000000},
      '{32'h402091b3, 4'd0,  32'h00000000},
      '{32'h0ff0000f, 4'd10, 32'h00000000},
      '{32'h300110f3, 4'd11, 32'h00000002},
      '{32'h300fd0f3, 4'd11, 32'h0000001f},
      '{32'h00000073, 4'd12, 32'h00000000},
      '{32'h00100073, 4'd13, 32'h00000000},
      '{32'h30200073, 4'd14, 32'h00000000},
      '{32'h00004073, 4'd0,  32'h00000000},
      '{32'h0000007f, 4'd0,  32'h00000000}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_instruction = v[i].ins;
      in_pc = 32'h200 + 32'(i * 4);
      step();
      if (v[i].cls == 4'd0) expInv++;
      checks++;
      if (out_valid !== 1'b1 || out_class !== v[i].cls ||
          out_invalid !== (v[i].cls == 4'd0)) begin
        errors++;
        $display("FAIL fmt_class[%0d] got v%0b c%0d i%0b want c%0d",
                 i, out_valid, out_class, out_invalid, v[i].cls);
      end
      checks++;
      if (out_immediate !== v[i].imm) begin
        errors++;
        $display("FAIL fmt_imm[%0d] got %0h want %0h",
                 i, out_immediate, v[i].imm);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_muldiv();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instruction = 32'h02208033;
    step();
    in_valid = 1'b0;
    expInv++;
    checks++;
    if (out_invalid !== 1'b1 || out_class !== 4'd0) begin
      errors++;
      $display("FAIL mul_nom got %0d/%0b want 0/1",
               out_class, out_invalid);
    end
    checks++;
    if (m_out_invalid !== 1'b0 || m_out_class !== 4'd15) begin
      errors++;
      $display("FAIL mul_m got %0d/%0b want 15/0",
               m_out_class, m_out_invalid);
    end
    step();
    checks++;
    if (invalid_count !== 8'(expInv)) begin
      errors++;
      $display("FAIL inv_count got %0d want %0d",
               invalid_count, expInv);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_instruction = 32'h00500093;
    in_valid = 1'b1;
    in_pc = 32'hA0;
    step();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_pc !== 32'hA0) begin
      errors++;
      $display("FAIL b2b_first got v%0b r%0b pc%0h want 1 1 a0",
               out_valid, in_ready, out_pc);
    end
    in_pc = 32'hB0;
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full got %0b want 0", in_ready);
    end
    in_pc = 32'hC0;
    step();
    checks++;
    if (in_ready !== 1'b0 || out_pc !== 32'hA0 || out_rd !== 5'd1) begin
      errors++;
      $display("FAIL b2b_hold got r%0b pc%0h rd%0d want 0 a0 1",
               in_ready, out_pc, out_rd);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hB0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got v%0b pc%0h r%0b want 1 b0 1",
               out_valid, out_pc, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hC0) begin
      errors++;
      $display("FAIL b2b_third got v%0b pc%0h want 1 c0",
               out_valid, out_pc);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty got %0b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_instruction = 32'h00500093;
    in_valid = 1'b1;
    in_pc = 32'hD0;
    step();
    in_pc = 32'hD4;
    step();
    in_pc = 32'hDEAD;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full got v%0b r%0b want 0 1",
               out_valid, in_ready);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_ghost got v%0b pc%0h want 0",
               out_valid, out_pc);
    end
    in_valid = 1'b1;
    in_pc = 32'hE0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept got %0b want 0", out_valid);
    end
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instruction = 32'h00004501;
    step();
    checks++;
    if (out_invalid !== 1'b1 || out_class !== 4'd0) begin
      errors++;
      $display("FAIL compressed got %0d/%0b want 0/1",
               out_class, out_invalid);
    end
    for (int i = 0; i < 259; i++) step();
    in_valid = 1'b0;
    step();
    checks++;
    if (invalid_count !== 8'hFF) begin
      errors++;
      $display("FAIL saturate got %0h want ff", invalid_count);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (invalid_count !== 8'hFF) begin
      errors++;
      $display("FAIL count_flush got %0h want ff", invalid_count);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_instruction = 32'h00500093;
    in_valid = 1'b1;
    in_pc = 32'hF0;
    step();
    in_pc = 32'hF4;
    step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_pc !== 32'h0 || out_rd !== 5'd0 ||
        out_immediate !== 32'h0 || invalid_count !== 8'h00) begin
      errors++;
      $display("FAIL async_rst got v%0b r%0b pc%0h rd%0d imm%0h cnt%0h want 0 1 0 0 0 0",
               out_valid, in_ready, out_pc, out_rd,
               out_immediate, invalid_count);
    end
    #1 rst = 1'b0;
    in_instruction = 32'h30200073;
    in_pc = 32'h80;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_class !== 4'd14 ||
        out_invalid !== 1'b0 || out_pc !== 32'h80) begin
      errors++;
      $display("FAIL mret_after got v%0b c%0d i%0b pc%0h want 1 14 0 80",
               out_valid, out_class, out_invalid, out_pc);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_formats();
    test_muldiv();
    test_back_to_back();
    test_flush();
    test_saturate();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode_stage.md
INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of the carried program counter.
REQ-002 SHALL have parameter ENABLE_M, default 0: 1 = decode RV32M (opcode 0110011, funct7 0000001) as class MULDIV; 0 = such words are invalid.
REQ-003 SHALL have parameter COUNT_WIDTH, default 8: width of the saturating invalid-instruction counter.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 flush  input  1  discard all held and incoming instructions.
REQ-008 in_valid  input  1  upstream word valid.
REQ-009 in_ready  output  1  stage can accept a word this cycle.
REQ-010 in_instruction  input  32  raw instruction word.
REQ-011 in_pc  input  ADDR_WIDTH  address of in_instruction.
REQ-012 out_valid  output  1  decoded record valid.
REQ-013 out_ready  input  1  downstream accepts record.
REQ-014 out_pc  output  ADDR_WIDTH  address of decoded record.
REQ-015 out_rd, out_rs1, out_rs2  output  5 each  register indices.
REQ-016 out_funct3  output  3; out_funct7  output  7  function fields.
REQ-017 out_immediate  output  32  sign-extended immediate for the decoded format.
REQ-018 out_class  output  4  instruction class code (REQ-023).
REQ-019 out_invalid  output  1  record is an illegal instruction.
REQ-020 invalid_count  output  COUNT_WIDTH  saturating count of invalid records accepted downstream.

Function
REQ-021 Decode SHALL be combinational on in_instruction; result captured into output register on accept (in_valid && in_ready && !flush).
REQ-022 Latency SHALL be 1 cycle from accept to out_valid when output register is empty or draining.
REQ-023 out_class codes: 0 none, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR(funct3 000), 5 BRANCH(funct3 not 010/011), 6 LOAD(funct3 000/001/010/100/101), 7 STORE(funct3 000/001/010), 8 ALUIMM(shift funct7 rules: SLLI 0000000, SRLI/SRAI 0000000/0100000), 9 ALU(funct7 0000000, or 0100000 with funct3 000/101), 10 FENCE(funct3 000), 11 CSR(opcode 1110011, funct3 not 000/100), 12 ECALL([31:7]=0), 13 EBREAK([31:7]=0x02000), 14 MRET([31:7]=0x0604000), 15 MULDIV.
REQ-024 out_invalid SHALL be 1 and out_class 0 when bits[1:0] != 11 (compressed), or no class matches.
REQ-025 Immediate: I-type for JALR/LOAD/ALUIMM; S for STORE; B for BRANCH; U for LUI/AUIPC; J for JAL; CSR = zero-extended rs1 field [19:15]; all others 0.
REQ-026 Buffering: 2-entry skid (output register + skid register); in_ready = !skid_valid (registered, never combinational from out_ready).
REQ-027 If out_valid && !out_ready and a word is accepted, it SHALL go to the skid register; when out_ready rises, skid moves to output next cycle.
REQ-028 Order SHALL be preserved; no record dropped or duplicated absent flush.
REQ-029 Output fields SHALL hold stable while out_valid && !out_ready.
REQ-030 flush SHALL clear out_valid and skid_valid next edge; word offered that cycle discarded; flush beats simultaneous accept.
REQ-031 invalid_count SHALL increment on out_valid && out_ready && out_invalid; saturate at all-ones; unaffected by flush.
REQ-032 Skid entries SHALL be cleared, not reused, after transfer (skid_valid 0).

Reset
REQ-033 On rst: out_valid 0, skid_valid 0, in_ready 1, invalid_count 0, all output fields 0, out_class 0, out_invalid 0.
REQ-034 rst asserted mid-transfer SHALL drop all held records immediately; first accept possible on first edge after rst deasserts.

Verification
REQ-035 in 0x00500093 (ADDI x1,x0,5), out_ready=1 -> next cycle out_valid 1, class 8, rd 1, imm 5.
REQ-036 out_ready=0, three back-to-back words -> two held, in_ready 0 after second; release -> delivered in order, third accepted after.
REQ-037 in 0x02208033 with ENABLE_M=0 -> out_invalid 1, class 0; ENABLE_M=1 -> class 15, invalid 0.
REQ-038 in 0x4501 (compressed) -> out_invalid 1; 256 invalid handshakes at COUNT_WIDTH=8 -> invalid_count stays 0xFF.
REQ-039 flush with both entries full and in_valid=1 -> out_valid 0, in_ready 1 next cycle, flushed-cycle word never appears.
REQ-040 rst pulse mid-stall -> outputs zero asynchronously; 0x30200073 after -> class 14.
